// File: rtl/cache.sv
// rtl/cache.sv - direct-mapped, write-back, write-allocate cache with a block-wide memory port
// Optional whole-cache flush of dirty lines is built only when CACHE_FLUSH_EN is defined.
module cache #(
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 2,
  parameter int INDEX_BITS  = 6
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic [ADDR_WIDTH+WORD_WIDTH+2:0]                           proc_req,
  output logic [WORD_WIDTH:0]                                        proc_res,
  output logic [ADDR_WIDTH-OFFSET_BITS+(2**OFFSET_BITS)*WORD_WIDTH+1:0] mem_req,
  input  logic [(2**OFFSET_BITS)*WORD_WIDTH:0]                       mem_res
);

  localparam int WORDS   = 2 ** OFFSET_BITS;
  localparam int BLOCK_W = WORDS * WORD_WIDTH;
  localparam int LINES   = 2 ** INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int BADDR_W = ADDR_WIDTH - OFFSET_BITS;

  typedef struct packed {
    logic                  cs;
    logic                  rw;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } proc_req_t;

  typedef struct packed {
    logic                  hold_cpu;
    logic [WORD_WIDTH-1:0] data;
  } proc_res_t;

  typedef struct packed {
    logic               cs;
    logic               rw;
    logic [BADDR_W-1:0] addr;
    logic [BLOCK_W-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic               ready;
    logic [BLOCK_W-1:0] data;
  } mem_res_t;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE
`ifdef CACHE_FLUSH_EN
    , FLUSH
`endif
  } state_t;

  proc_req_t req_in;
  proc_res_t res_out;
  mem_req_t  mreq;
  mem_res_t  mres;

  assign req_in   = proc_req;
  assign mres     = mem_res;
  assign proc_res = res_out;
  assign mem_req  = mreq;

  state_t                state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_WIDTH-1:0] req_data;
  logic                  req_rw;
  logic [WORD_WIDTH-1:0] rdata_q;
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [BLOCK_W-1:0]    data_mem [LINES];

  logic [INDEX_BITS-1:0]  idx;
  logic [OFFSET_BITS-1:0] off;
  logic [TAG_W-1:0]       tag;
  logic [TAG_W-1:0]       line_tag;
  logic [BLOCK_W-1:0]     line_blk;
  logic                   hit;
  logic [WORD_WIDTH-1:0]  hit_word;

  assign idx      = req_addr[OFFSET_BITS +: INDEX_BITS];
  assign off      = req_addr[OFFSET_BITS-1:0];
  assign tag      = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign line_tag = tag_mem[idx];
  assign line_blk = data_mem[idx];
  assign hit      = valid_q[idx] && (line_tag == tag);
  assign hit_word = line_blk[int'(off)*WORD_WIDTH +: WORD_WIDTH];

`ifdef CACHE_FLUSH_EN
  logic [INDEX_BITS-1:0] flush_idx;
  logic                  flush_dirty;
  assign flush_dirty = valid_q[flush_idx] && dirty_q[flush_idx];
`else
  logic unused_flush;
  assign unused_flush = req_in.flush;
`endif

  // Outputs are decoded from the registered state and line arrays; reset masks the IDLE stall echo.
  always_comb begin
    res_out.hold_cpu = 1'b0;
    res_out.data     = rdata_q;
    mreq             = '0;
    if (rst) begin
      case (state)
        IDLE: res_out.hold_cpu = req_in.cs;
        COMPARE: begin
          res_out.hold_cpu = !hit;
          if (hit && !req_rw) res_out.data = hit_word;
        end
        WRITE_BACK: begin
          res_out.hold_cpu = 1'b1;
          mreq.cs          = 1'b1;
          mreq.rw          = 1'b1;
          mreq.addr        = {line_tag, idx};
          mreq.data        = line_blk;
        end
        ALLOCATE: begin
          res_out.hold_cpu = 1'b1;
          mreq.cs          = 1'b1;
          mreq.addr        = req_addr[ADDR_WIDTH-1:OFFSET_BITS];
        end
`ifdef CACHE_FLUSH_EN
        FLUSH: begin
          res_out.hold_cpu = 1'b1;
          if (flush_dirty) begin
            mreq.cs   = 1'b1;
            mreq.rw   = 1'b1;
            mreq.addr = {tag_mem[flush_idx], flush_idx};
            mreq.data = data_mem[flush_idx];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req_addr <= '0;
      req_data <= '0;
      req_rw   <= 1'b0;
      rdata_q  <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
`ifdef CACHE_FLUSH_EN
      flush_idx <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_in.cs) begin
            req_addr <= req_in.addr;
            req_data <= req_in.data;
            req_rw   <= req_in.rw;
`ifdef CACHE_FLUSH_EN
            if (req_in.flush) begin
              state     <= FLUSH;
              flush_idx <= '0;
            end else
`endif
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (req_rw) dirty_q[idx] <= 1'b1;
            else rdata_q <= hit_word;
            state <= IDLE;
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state <= WRITE_BACK;
          end else begin
            state <= ALLOCATE;
          end
        end
        WRITE_BACK: begin
          if (mres.ready) begin
            dirty_q[idx] <= 1'b0;
            state        <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mres.ready) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            state        <= COMPARE;
          end
        end
`ifdef CACHE_FLUSH_EN
        // Clean lines are skipped in one cycle; dirty ones wait for the write-back handshake.
        FLUSH: begin
          if (!flush_dirty || mres.ready) begin
            if (flush_dirty) dirty_q[flush_idx] <= 1'b0;
            if (&flush_idx) state <= IDLE;
            else flush_idx <= flush_idx + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ALLOCATE && mres.ready) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mres.data;
    end else if (state == COMPARE && hit && req_rw) begin
      data_mem[idx][int'(off)*WORD_WIDTH +: WORD_WIDTH] <= req_data;
    end
  end

endmodule

// File: tb/tb_cache.sv
// tb/tb_cache.sv - directed self-checking bench for cache with a latency-programmable memory model
// Flush checks are selected by CACHE_FLUSH_EN to match the build under test.
module tb_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [66:0]  proc_req;
  logic [32:0]  proc_res;
  logic [159:0] mem_req;
  logic [128:0] mem_res;

  always #5 clk = ~clk;

  cache dut (
    .clk      (clk),
    .rst      (rst),
    .proc_req (proc_req),
    .proc_res (proc_res),
    .mem_req  (mem_req),
    .mem_res  (mem_res)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 1;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int unstable = 0;
  logic [29:0] last_rd = '0;
  logic [29:0] wr_log [$];
  logic [31:0] wr_word0 [$];
  logic [31:0] mem_model [logic [31:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'hC0DE0000 | a;
  endfunction

  // Memory controller: accepts a request seen at a falling edge, raises ready after lat cycles.
  initial begin
    logic [159:0] snap;
    logic [127:0] blk;
    logic         abort;
    logic [1:0]   wi;
    mem_res = '0;
    forever begin
      @(negedge clk);
      mem_res = '0;
      if (rst && mem_req[159]) begin
        snap  = mem_req;
        abort = 1'b0;
        blk   = '0;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (!rst) begin
            abort = 1'b1;
            break;
          end
          if (mem_req !== snap) unstable++;
        end
        if (!abort) begin
          if (snap[158]) begin
            for (int w = 0; w < 4; w++) begin
              wi = w[1:0];
              mem_model[{snap[157:128], wi}] = snap[w*32 +: 32];
            end
            wr_cnt++;
            wr_log.push_back(snap[157:128]);
            wr_word0.push_back(snap[31:0]);
          end else begin
            for (int w = 0; w < 4; w++) begin
              wi = w[1:0];
              blk[w*32 +: 32] = mem_word({snap[157:128], wi});
            end
            rd_cnt++;
            last_rd = snap[157:128];
          end
          mem_res = {1'b1, blk};
        end
      end
    end
  end

  // Edges counts the latching edge through the edge that completes the request.
  task automatic do_req(input logic rw, input logic flush, input logic [31:0] addr,
                        input logic [31:0] data, input int l, output int edges,
                        output logic [31:0] rd);
    lat = l;
    proc_req = {1'b1, rw, flush, addr, data};
    @(posedge clk);
    #1 proc_req[66] = 1'b0;
    edges = 1;
    forever begin
      @(negedge clk);
      if (!proc_res[32]) break;
      @(posedge clk);
      edges++;
      if (edges > 600) begin
        check("timeout_hold", {63'd0, proc_res[32]}, 64'd0);
        break;
      end
    end
    rd = proc_res[31:0];
    @(posedge clk);
    edges++;
    #1;
  endtask

  int          e;
  logic [31:0] d;
  int          r0;
  int          w0;

  initial begin
    rst      = 1'b0;
    proc_req = {1'b1, 2'b00, 32'h10, 32'h0};
    #12;
    check("rst_hold", {63'd0, proc_res[32]}, 64'd0);
    check("rst_mem_cs", {63'd0, mem_req[159]}, 64'd0);
    check("rst_mem_req", {32'd0, mem_req[159:128]}, 64'd0);
    check("rst_rdata", {32'd0, proc_res[31:0]}, 64'd0);
    @(negedge clk);
    proc_req = '0;
    rst      = 1'b1;
    @(negedge clk);

    lat      = 5;
    proc_req = {1'b1, 2'b00, 32'h10, 32'h0};
    @(posedge clk);
    #1 proc_req[66] = 1'b0;
    repeat (3) @(posedge clk);
    check("miss_wait_cs", {63'd0, mem_req[159]}, 64'd1);
    #3 rst = 1'b0;
    #1;
    check("midrst_hold", {63'd0, proc_res[32]}, 64'd0);
    check("midrst_mem_cs", {63'd0, mem_req[159]}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    r0 = rd_cnt;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 1, e, d);
    check("postrst_edges", e, 4);
    check("postrst_reads", rd_cnt, r0 + 1);
    check("postrst_data", {32'd0, d}, 64'hC0DE0010);

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1, e, d);
    check("cold_st_edges", e, 4);
    check("cold_st_reads", rd_cnt, r0 + 1);
    check("cold_st_blk", {34'd0, last_rd}, 64'h004);
    check("cold_st_writes", wr_cnt, w0);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 1, e, d);
    check("hit_ld_edges", e, 2);
    check("hit_ld_data", {32'd0, d}, 64'hDEADBEEF);
    check("hit_ld_reads", rd_cnt, r0 + 1);

    do_req(1'b0, 1'b0, 32'h110, 32'h0, 1, e, d);
    check("dirty_edges", e, 5);
    check("dirty_writes", wr_cnt, w0 + 1);
    check("dirty_wb_blk", {34'd0, wr_log[$]}, 64'h004);
    check("dirty_wb_word0", {32'd0, wr_word0[$]}, 64'hDEADBEEF);
    check("dirty_rd_blk", {34'd0, last_rd}, 64'h044);
    check("dirty_data", {32'd0, d}, 64'hC0DE0110);

    w0 = wr_cnt;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 5, e, d);
    check("clean_ev_edges", e, 8);
    check("clean_ev_writes", wr_cnt, w0);
    check("clean_ev_data", {32'd0, d}, 64'hDEADBEEF);

    do_req(1'b0, 1'b0, 32'h110, 32'h0, 1, e, d);
    check("lat1_edges", e, 4);
    check("lat1_data", {32'd0, d}, 64'hC0DE0110);
    do_req(1'b0, 1'b0, 32'h211, 32'h0, 5, e, d);
    check("lat5_edges", e, 8);
    check("lat5_data", {32'd0, d}, 64'hC0DE0211);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 1, e, d);
    check("lat1_ld010_data", {32'd0, d}, 64'hDEADBEEF);
    check("clean_ev_writes2", wr_cnt, w0);
    check("mem_req_stable", unstable, 0);

    do_req(1'b1, 1'b0, 32'h10, 32'h12345678, 1, e, d);
    check("st_hit_edges", e, 2);
    check("st_hit_rdata", {32'd0, d}, 64'hDEADBEEF);
    check("rdata_held", {32'd0, proc_res[31:0]}, 64'hDEADBEEF);

`ifdef CACHE_FLUSH_EN
    do_req(1'b1, 1'b0, 32'h24, 32'hCAFEF00D, 1, e, d);
    check("st9_edges", e, 4);
    w0 = wr_cnt;
    r0 = rd_cnt;
    do_req(1'b0, 1'b1, 32'h0, 32'h0, 2, e, d);
    check("flush_writes", wr_cnt, w0 + 2);
    check("flush_first_blk", {34'd0, wr_log[$-1]}, 64'h004);
    check("flush_second_blk", {34'd0, wr_log[$]}, 64'h009);
    check("flush_first_w0", {32'd0, wr_word0[$-1]}, 64'h12345678);
    check("flush_second_w0", {32'd0, wr_word0[$]}, 64'hCAFEF00D);
    check("flush_hold_after", {63'd0, proc_res[32]}, 64'd0);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 1, e, d);
    check("post_flush_edges", e, 2);
    check("post_flush_data", {32'd0, d}, 64'h12345678);
    check("post_flush_reads", rd_cnt, r0);
`else
    w0 = wr_cnt;
    do_req(1'b0, 1'b1, 32'h10, 32'h0, 1, e, d);
    check("noflush_edges", e, 2);
    check("noflush_data", {32'd0, d}, 64'h12345678);
    check("noflush_writes", wr_cnt, w0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 The block SHALL take parameter WORD_WIDTH, default 32, data word width.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 32, processor word-address width.
REQ-003 The block SHALL take parameter OFFSET_BITS, default 2, word-in-block bits (4 words/block).
REQ-004 The block SHALL take parameter INDEX_BITS, default 6, line-index bits (64 lines).
REQ-005 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port proc_req, input, struct {cs 1, rw 1 (1=write), flush 1, addr ADDR_WIDTH, data WORD_WIDTH}, processor request.
REQ-008 The block SHALL have port proc_res, output, struct {hold_cpu 1, data WORD_WIDTH}, processor stall and read data.
REQ-009 The block SHALL have port mem_req, output, struct {cs 1, rw 1, addr ADDR_WIDTH-OFFSET_BITS (block address), data 2^OFFSET_BITS*WORD_WIDTH}, block request to mem_ctrl.
REQ-010 The block SHALL have port mem_res, input, struct {ready 1, data 2^OFFSET_BITS*WORD_WIDTH}, mem_ctrl response.

Function
REQ-011 The cache SHALL be direct-mapped, write-back, write-allocate; index = addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], tag = remaining upper bits; per line: valid, dirty, tag, block.
REQ-012 FSM states SHALL be IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH.
REQ-013 IDLE: hold_cpu SHALL equal proc_req.cs combinationally; at an edge with cs=1 the request SHALL be latched and the FSM SHALL go to COMPARE.
REQ-014 COMPARE hit: hold_cpu=0; read drives the addressed word on proc_res.data; write updates the word and sets dirty at the edge; next state IDLE.
REQ-015 COMPARE miss: hold_cpu=1; next state WRITE_BACK if line valid and dirty, else ALLOCATE.
REQ-016 WRITE_BACK: mem_req.cs=1, rw=1, addr={old tag,index}, data=line block; on mem_res.ready clear dirty and go to ALLOCATE.
REQ-017 ALLOCATE: mem_req.cs=1, rw=0, addr={new tag,index}; on mem_res.ready load block, set valid, clear dirty, store tag, return to COMPARE (which then hits).
REQ-018 mem_req.cs SHALL be 0 in IDLE and COMPARE; mem_req fields SHALL stay stable until ready; any ready latency >=1 cycle SHALL be tolerated.
REQ-019 Hit latency SHALL be 2 edges from cs assertion to hold_cpu=0; clean miss = hit + memory latency + 1; dirty miss adds one write-back transfer.
REQ-020 proc_res.data SHALL hold the last read value until the next completed read.
REQ-021 proc_req SHALL be ignored outside IDLE (the latched copy is used); cs=0 in IDLE SHALL keep hold_cpu=0.

Reset
REQ-022 rst low SHALL immediately force IDLE, clear all valid and dirty bits, drive hold_cpu=0, proc_res.data=0, mem_req all zero.
REQ-023 Reset mid-miss or mid-flush SHALL abort the transfer; dirty data SHALL be discarded.

Configuration
REQ-024 With CACHE_FLUSH_EN defined, proc_req.cs=1 with flush=1 in IDLE SHALL enter FLUSH: write back every valid dirty line in index order via the WRITE_BACK handshake, clear its dirty bit, hold_cpu=1 throughout, then IDLE with hold_cpu=0; lines stay valid.
REQ-025 Without CACHE_FLUSH_EN, flush SHALL be ignored and the request handled as a normal read/write; FLUSH state logic SHALL not be built.

Verification
REQ-026 Reset: rst=0 mid-operation -> hold_cpu=0, mem_req.cs=0 immediately; next LD 0x010 misses.
REQ-027 Cold ST 0x010 data 0xDEADBEEF -> one read of block 0x004, then hold_cpu=0; LD 0x010 -> 0xDEADBEEF in 2 edges, no mem_req.cs.
REQ-028 After REQ-027, LD 0x110 -> write-back of block 0x004 with word0=0xDEADBEEF, then read of block 0x044, data = memory word 0x110.
REQ-029 After REQ-028, LD 0x010 -> clean eviction (no write-back), returns 0xDEADBEEF from memory.
REQ-030 mem_ctrl ready delayed 1 vs 5 cycles -> identical data, mem_req stable while waiting.
REQ-031 With CACHE_FLUSH_EN: dirty lines 4 and 9, flush -> write-backs to blocks of line 4 then 9, hold_cpu drops after second; without macro, flush=1 rw=0 addr 0x010 -> normal read.
